// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan decoder: glyph table,
// blanking constants and the capture FSM state type.
package seg_pkg;

  // Active-low segment patterns (g..a) for hex digits; entry i shows digit i.
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // All segments dark.
  localparam logic [6:0] BLANK = 7'h7F;

  // No digit select asserted (display blanking interval).
  localparam logic [3:0] DIG_NONE = 4'hF;

  typedef enum logic [1:0] {
    SCAN,
    CAPTURE,
    LOCKED
  } state_t;

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational glyph decoder: maps an active-low 7-segment pattern back to
// the hex digit it shows. Unknown patterns (including blank) decode to 0
// with ok low.
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic [3:0] value
);

  // Search the glyph table; a blank pattern never matches any entry.
  always_comb begin
    ok    = 1'b0;
    value = 4'h0;
    if (seg != BLANK) begin
      for (int i = 0; i < 16; i++) begin
        if (seg == GLYPH[i]) begin
          ok    = 1'b1;
          value = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiving end of a multiplexed 7-segment display: synchronizes SEG/DIG,
// waits for each digit activation to settle, captures it once into a shadow
// slot and hands out complete 4-digit frames over a valid/ready handshake.
// Optional feature macro: SEG_ERR_CNT_EN adds the ERR_CNT output.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        FPGA_CLK,
  input  logic        RST_N,
  input  logic [7:0]  SEG,
  input  logic [3:0]  DIG,
  output logic [15:0] VALUE,
  output logic [3:0]  DP_OUT,
  output logic [3:0]  DIGIT_OK,
  output logic        FRAME_VALID,
  input  logic        FRAME_READY,
  output logic        OVERRUN
`ifdef SEG_ERR_CNT_EN
  ,
  output logic [7:0]  ERR_CNT
`endif
);
  import seg_pkg::*;

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic              [1:0] rst_sync_reg;
  logic                    rst_int_n;
  logic             [11:0] sync_reg [SYNC_STAGES];
  logic             [11:0] prev_reg;
  logic              [7:0] seg_s;
  logic              [3:0] dig_s;
  logic        [CNT_W-1:0] cnt_reg;
  state_t                  state_reg;
  logic              [3:0] cap_dig_reg;
  logic              [3:0] mask_reg;
  logic         [3:0][3:0] shadow_val_reg;
  logic         [3:0][3:0] shadow_val_next;
  logic              [3:0] shadow_ok_reg;
  logic              [3:0] shadow_ok_next;
  logic              [3:0] shadow_dp_reg;
  logic              [3:0] shadow_dp_next;
  logic                    glyph_ok;
  logic              [3:0] glyph_val;
  logic              [3:0] sel;
  logic                    partial_sel;
  logic                    slot_ok;
  logic                    capture_en;
  logic              [3:0] mask_next;
  logic                    complete;
  logic                    handshake;
  logic             [15:0] value_reg;
  logic              [3:0] dp_reg;
  logic              [3:0] ok_reg;
  logic                    valid_reg;
  logic                    overrun_reg;

  // Reset asserts immediately and releases two clocks after RST_N rises.
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  // Multi-flop synchronizer on {SEG, DIG}; idles at all ones (everything dark).
  always_ff @(posedge FPGA_CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '1;
    end else begin
      sync_reg[0] <= {SEG, DIG};
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end
  assign {seg_s, dig_s} = sync_reg[SYNC_STAGES-1];

  // Stability counter: restarts on any change, saturates once settled.
  always_ff @(posedge FPGA_CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      prev_reg <= '1;
      cnt_reg  <= '0;
    end else begin
      prev_reg <= {seg_s, dig_s};
      if ({seg_s, dig_s} != prev_reg)           cnt_reg <= '0;
      else if (cnt_reg != CNT_W'(STABLE_CYCLES)) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Capture FSM: one capture per digit activation, blanking forces SCAN.
  always_ff @(posedge FPGA_CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg   <= SCAN;
      cap_dig_reg <= DIG_NONE;
    end else if (dig_s == DIG_NONE) begin
      state_reg <= SCAN;
    end else begin
      case (state_reg)
        SCAN:    if (cnt_reg == CNT_W'(STABLE_CYCLES)) state_reg <= CAPTURE;
        CAPTURE: begin
          state_reg   <= LOCKED;
          cap_dig_reg <= dig_s;
        end
        LOCKED:  if (dig_s != cap_dig_reg) state_reg <= SCAN;
        default: state_reg <= SCAN;
      endcase
    end
  end

  seg_glyph_dec u_glyph (
    .seg   (seg_s[6:0]),
    .ok    (glyph_ok),
    .value (glyph_val)
  );

  // Selected slots are the low DIG bits; 2 or 3 selected is a driver fault,
  // while all four selected is a legal "same digit everywhere" broadcast.
  assign sel         = ~dig_s;
  assign partial_sel = (sel != 4'hF) && ((sel & (sel - 4'd1)) != 4'd0);
  assign slot_ok     = glyph_ok & ~partial_sel;
  assign capture_en  = (state_reg == CAPTURE) && (dig_s != DIG_NONE);
  assign mask_next   = mask_reg | sel;
  assign complete    = capture_en && (mask_next == 4'hF);
  assign handshake   = valid_reg & FRAME_READY;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign shadow_val_next[gi] = (capture_en && sel[gi]) ? glyph_val  : shadow_val_reg[gi];
    assign shadow_ok_next[gi]  = (capture_en && sel[gi]) ? slot_ok    : shadow_ok_reg[gi];
    assign shadow_dp_next[gi]  = (capture_en && sel[gi]) ? ~seg_s[7]  : shadow_dp_reg[gi];
  end

  // Shadow slots and capture mask; the mask restarts when a frame completes.
  always_ff @(posedge FPGA_CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      shadow_val_reg <= '0;
      shadow_ok_reg  <= '0;
      shadow_dp_reg  <= '0;
      mask_reg       <= '0;
    end else if (capture_en) begin
      shadow_val_reg <= shadow_val_next;
      shadow_ok_reg  <= shadow_ok_next;
      shadow_dp_reg  <= shadow_dp_next;
      mask_reg       <= complete ? 4'h0 : mask_next;
    end
  end

  // Output frame register: loads on completion unless a frame is still
  // pending without a handshake, in which case the new frame is dropped.
  always_ff @(posedge FPGA_CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      value_reg   <= '0;
      dp_reg      <= '0;
      ok_reg      <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (complete) begin
      if (!valid_reg || handshake) begin
        value_reg <= shadow_val_next;
        dp_reg    <= shadow_dp_next;
        ok_reg    <= shadow_ok_next;
        valid_reg <= 1'b1;
      end else begin
        overrun_reg <= 1'b1;
      end
    end else if (handshake) begin
      valid_reg <= 1'b0;
    end
  end

  assign VALUE       = value_reg;
  assign DP_OUT      = dp_reg;
  assign DIGIT_OK    = ok_reg;
  assign FRAME_VALID = valid_reg;
  assign OVERRUN     = overrun_reg;

`ifdef SEG_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  // Count captures that wrote a bad slot, saturating at 255.
  always_ff @(posedge FPGA_CLK or negedge rst_int_n) begin
    if (!rst_int_n) err_cnt_reg <= 8'd0;
    else if (capture_en && !slot_ok && (err_cnt_reg != 8'hFF))
      err_cnt_reg <= err_cnt_reg + 8'd1;
  end
  assign ERR_CNT = err_cnt_reg;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scans plus randomized
// frames, compared against a slot/frame model built from the glyph rules.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic [15:0] value;
  logic [3:0]  dp_out;
  logic [3:0]  digit_ok;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;
`ifdef SEG_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [3:0] m_val [4];
  logic       m_ok  [4];
  logic       m_dp  [4];
  logic [3:0] m_mask;
  logic [15:0] e_value;
  logic [3:0]  e_dp;
  logic [3:0]  e_ok;
  logic        m_valid;
  logic        m_ovr;
  int          m_err;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_decoder #(.STABLE_CYCLES(16), .SYNC_STAGES(2)) dut (
    .FPGA_CLK    (clk),
    .RST_N       (rst_n),
    .SEG         (seg),
    .DIG         (dig),
    .VALUE       (value),
    .DP_OUT      (dp_out),
    .DIGIT_OK    (digit_ok),
    .FRAME_VALID (frame_valid),
    .FRAME_READY (frame_ready),
    .OVERRUN     (overrun)
`ifdef SEG_ERR_CNT_EN
    ,
    .ERR_CNT     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int glyph_idx(input logic [6:0] p);
    int r = -1;
    for (int i = 0; i < 16; i++) if (glyph_tab[i] == p) r = i;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 4'h0; m_ok[i] = 1'b0; m_dp[i] = 1'b0;
    end
    m_mask = 4'h0; e_value = 16'h0; e_dp = 4'h0; e_ok = 4'h0;
    m_valid = 1'b0; m_ovr = 1'b0; m_err = 0;
  endtask

  // One settled digit activation: record what the display showed.
  task automatic model_capture(input logic [7:0] s, input logic [3:0] d);
    int lows = 0;
    int idx;
    bit bad = 0;
    for (int i = 0; i < 4; i++) if (!d[i]) lows++;
    if (lows == 0) return;
    idx = glyph_idx(s[6:0]);
    for (int i = 0; i < 4; i++) begin
      if (!d[i]) begin
        m_val[i] = (idx < 0) ? 4'h0 : 4'(idx);
        m_ok[i]  = (idx >= 0) && (lows == 1 || lows == 4);
        m_dp[i]  = ~s[7];
        m_mask[i] = 1'b1;
        if (!m_ok[i]) bad = 1;
      end
    end
    if (bad && m_err < 255) m_err++;
    if (m_mask == 4'hF) begin
      m_mask = 4'h0;
      if (!m_valid) begin
        for (int i = 0; i < 4; i++) begin
          e_value[4*i +: 4] = m_val[i];
          e_dp[i] = m_dp[i];
          e_ok[i] = m_ok[i];
        end
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic activate(input logic [7:0] s, input logic [3:0] d);
    seg = s; dig = d;
    step(24);
    model_capture(s, d);
  endtask

  task automatic blank(input int n);
    seg = 8'hFF; dig = 4'hF;
    step(n);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/valid"}, {15'd0, frame_valid}, {15'd0, m_valid});
    chk({tag, "/value"}, value, e_value);
    chk({tag, "/dp"}, {12'd0, dp_out}, {12'd0, e_dp});
    chk({tag, "/ok"}, {12'd0, digit_ok}, {12'd0, e_ok});
    chk({tag, "/overrun"}, {15'd0, overrun}, {15'd0, m_ovr});
`ifdef SEG_ERR_CNT_EN
    chk({tag, "/errcnt"}, {8'd0, err_cnt}, 16'(m_err));
`endif
    $display("frame %s: value=%h dp=%b ok=%b valid=%b overrun=%b", tag, value, dp_out,
             digit_ok, frame_valid, overrun);
  endtask

  task automatic handshake(input string tag);
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    m_valid = 1'b0;
    chk({tag, "/valid_drop"}, {15'd0, frame_valid}, 16'd0);
  endtask

  initial begin
    logic [3:0] order [4];
    logic [6:0] pat;
    logic [7:0] s;
    int j;
    logic [3:0] t;

    rst_n = 1'b0; seg = 8'hFF; dig = 4'hF; frame_ready = 1'b0;
    model_reset();
    step(3);
    check_all("reset");
    rst_n = 1'b1;
    step(4);

    // Plain scan of digits 0..3
    activate(8'hC0, 4'b1110);
    activate(8'hF9, 4'b1101);
    activate(8'hA4, 4'b1011);
    activate(8'hB0, 4'b0111);
    blank(4);
    check_all("scan0123");
    step(10);
    check_all("scan0123_hold");
    handshake("scan0123");
    frame_ready = 1'b1; step(2); frame_ready = 1'b0;
    check_all("ready_idle");

    // All digits selected at once: one capture fills the frame
    activate(8'h92, 4'b0000);
    blank(4);
    check_all("broadcast5");
    handshake("broadcast5");

    // SEG glitching faster than the stability window on slot 0
    dig = 4'b1110;
    for (int k = 0; k < 12; k++) begin
      seg = k[0] ? 8'hC0 : 8'hF9;
      step(8);
      chk("glitch/valid", {15'd0, frame_valid}, 16'd0);
    end
    activate(8'hF9, 4'b1101);
    activate(8'hFF, 4'b1011);
    activate(8'h06, 4'b0111);
    blank(4);
    check_all("glitch_partial");
    activate(8'hC0, 4'b1110);
    blank(4);
    check_all("blank_slot_dp");
    handshake("blank_slot_dp");

    // Randomized frames in random slot order
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) order[i] = 4'(i);
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) pat = 7'($urandom);
        else pat = glyph_tab[$urandom_range(0, 15)];
        s = {1'($urandom_range(0, 1)), pat};
        activate(s, ~(4'b0001 << order[i]));
      end
      blank(4);
      check_all("random");
      handshake("random");
    end

    // Two frames without a consumer: first retained, overrun sticks
    activate(8'hF9, 4'b1110);
    activate(8'hA4, 4'b1101);
    activate(8'hB0, 4'b1011);
    activate(8'h99, 4'b0111);
    blank(4);
    check_all("ovr_first");
    activate(8'h92, 4'b1110);
    activate(8'h82, 4'b1101);
    activate(8'hF8, 4'b1011);
    activate(8'h80, 4'b0111);
    blank(4);
    check_all("ovr_second");
    handshake("ovr");
    check_all("ovr_sticky");

    // Two digit selects low at once marks both slots bad
    activate(8'hF9, 4'b1100);
    activate(8'hA4, 4'b1011);
    activate(8'hB0, 4'b0111);
    blank(4);
    check_all("double_sel");
    handshake("double_sel");

    // Reset in the middle of a scan discards the partial frame
    activate(8'hC0, 4'b1110);
    activate(8'hF9, 4'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    seg = 8'hFF; dig = 4'hF;
    step(2);
    rst_n = 1'b1;
    step(4);
    activate(8'hA4, 4'b1011);
    activate(8'hB0, 4'b0111);
    blank(4);
    check_all("after_reset_partial");
    activate(8'h88, 4'b1110);
    activate(8'h83, 4'b1101);
    blank(4);
    check_all("after_reset_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
